// File: rtl/switch_counter_ctrl_pkg.sv
// switch_counter_ctrl_pkg: shared FSM state encoding and count-direction constants
package switch_counter_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;
endpackage

// File: rtl/switch_counter_ctrl_tick_prescaler.sv
// switch_counter_ctrl_tick_prescaler: divides clk into a one-cycle tick every TICK_DIV enabled cycles
// Ports: clk, rst (async active-low), clr (sync clear), en (count enable), tick (one-cycle pulse)
module switch_counter_ctrl_tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  logic [PW-1:0] cnt;
  assign tick = en && cnt == LAST;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/switch_counter_ctrl.sv
// switch_counter_ctrl: switch-loaded up/down counter stepping at a prescaled rate with pause/resume
// Ports: clk, rst (async active-low), switch_in (load value/target), start, pause (toggle), mode_up,
//        led_out (live count), busy (LOAD/RUN/PAUSE), done (one-cycle completion pulse)
module switch_counter_ctrl
  import switch_counter_ctrl_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switch_in,
  input  logic             start,
  input  logic             pause,
  input  logic             mode_up,
  output logic [WIDTH-1:0] led_out,
  output logic             busy,
  output logic             done
);
  state_t state;
  logic [WIDTH-1:0] target, next_count;
  logic dir, tick, at_end;
  switch_counter_ctrl_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk (clk),
    .rst (rst),
    .clr (state == S_LOAD),
    .en  (state == S_RUN),
    .tick(tick)
  );
  assign next_count = (dir == DIR_UP) ? led_out + 1'b1 : led_out - 1'b1;
  // Terminal check is on the post-step value, so the count never steps past 0 or target
  assign at_end = next_count == ((dir == DIR_UP) ? target : '0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= S_IDLE;
      led_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      target  <= '0;
      dir     <= DIR_DOWN;
    end else begin
      done <= 1'b0;
      // A start while busy restarts; a zero switch value aborts to IDLE with a cleared display
      if (start && (state == S_LOAD || state == S_RUN || state == S_PAUSE)) begin
        state <= (switch_in != '0) ? S_LOAD : S_IDLE;
        busy  <= switch_in != '0;
        if (switch_in == '0) led_out <= '0;
      end else
        case (state)
          S_IDLE:
            if (start && switch_in != '0) begin
              state <= S_LOAD;
              busy  <= 1'b1;
            end
          S_LOAD: begin
            target  <= switch_in;
            dir     <= mode_up;
            led_out <= (mode_up == DIR_UP) ? '0 : switch_in;
            state   <= S_RUN;
          end
          S_RUN:
            // A completing tick beats a simultaneous pause
            if (tick && at_end) begin
              led_out <= next_count;
              state   <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              if (tick) led_out <= next_count;
              if (pause) state <= S_PAUSE;
            end
          S_PAUSE: if (pause) state <= S_RUN;
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_switch_counter_ctrl.sv
// tb_switch_counter_ctrl: self-checking bench for switch_counter_ctrl with a timing-formula reference model
module tb_switch_counter_ctrl;
  localparam int W  = 16;
  localparam int TD = 4;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, pause = 1'b0, mode_up = 1'b0;
  logic [W-1:0] switch_in = '0;
  logic [W-1:0] led_out;
  logic busy, done;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  switch_counter_ctrl #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .switch_in(switch_in), .start(start), .pause(pause),
    .mode_up(mode_up), .led_out(led_out), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycles spent counting among the first n cycles after RUN entry, excluding a paused window of h cycles
  function automatic int rcyc(input int n, input int a, input int h);
    int r = 0;
    for (int j = 0; j < n; j++)
      if (!(a >= 0 && j >= a + 1 && j <= a + h)) r++;
    return r;
  endfunction

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int sw, input bit up, input bit sp);
    switch_in = W'(sw);
    mode_up   = up;
    start     = 1'b1;
    pause     = sp;
    cyc1();
    start = 1'b0;
    pause = 1'b0;
  endtask

  // Full count of v steps; a = sample index of a pause pulse (-1 for none), resumed h cycles later
  task automatic scenario(input int v, input bit up, input int a, input int h, input bit sp);
    int chg  = $urandom_range(1, 4 * v);
    int last = 4 * v + (a >= 0 ? h : 0) + 2;
    do_start(v, up, sp);
    chk("load_busy", busy, 1);
    chk("load_done", done, 0);
    cyc1();
    for (int n = 0; n <= last; n++) begin
      int r = rcyc(n, a, h);
      int s = (r / TD < v) ? r / TD : v;
      chk("led", led_out, up ? s : v - s);
      chk("busy", busy, r < 4 * v);
      chk("done", done, r == 4 * v && rcyc(n - 1, a, h) < 4 * v);
      pause = (n == a) || (a >= 0 && n == a + h);
      if (n == chg) begin
        switch_in = W'($urandom);
        mode_up   = ~mode_up;
      end
      cyc1();
      pause = 1'b0;
    end
  endtask

  initial begin
    start = 1'b1;
    switch_in = 16'd5;
    repeat (3) cyc1();
    chk("rst_led", led_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    start = 1'b0;
    rst = 1'b1;
    cyc1();
    cyc1();
    chk("idle_busy", busy, 0);
    chk("idle_led", led_out, 0);
    scenario(3, 0, -1, 0, 0);
    scenario(5, 1, -1, 0, 0);
    do_start(0, 0, 0);
    chk("zero_busy", busy, 0);
    cyc1();
    chk("zero_busy2", busy, 0);
    chk("zero_led_hold", led_out, 5);
    scenario(4, 0, 8, 20, 0);
    do_start(5, 0, 0);
    repeat (6) cyc1();
    chk("pre_restart", led_out, 4);
    scenario(7, 0, -1, 0, 0);
    do_start(6, 1, 0);
    repeat (4) cyc1();
    scenario(3, 1, -1, 0, 1);
    do_start(6, 0, 0);
    repeat (3) cyc1();
    chk("pre_abort", led_out, 6);
    do_start(0, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_led", led_out, 0);
    cyc1();
    chk("abort_done", done, 0);
    do_start(2, 0, 0);
    repeat (8) cyc1();
    pause = 1'b1;
    cyc1();
    pause = 1'b0;
    chk("donewins_done", done, 1);
    chk("donewins_led", led_out, 0);
    cyc1();
    chk("donewins_busy", busy, 0);
    chk("donewins_done2", done, 0);
    for (int i = 0; i < 12; i++) begin
      int v = $urandom_range(1, 8);
      int a = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 4 * v - 2);
      scenario(v, 1'($urandom_range(0, 1)), a, $urandom_range(1, 12), 1'($urandom_range(0, 1)));
    end
    do_start(6, 1, 0);
    repeat (10) cyc1();
    chk("pre_areset", led_out, 2);
    #3 rst = 1'b0;
    #1;
    chk("areset_led", led_out, 0);
    chk("areset_busy", busy, 0);
    chk("areset_done", done, 0);
    repeat (2) cyc1();
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      chk("post_areset_done", done, 0);
      chk("post_areset_led", led_out, 0);
      cyc1();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
